// File: rtl/my_decoder.sv
// rtl/my_decoder.sv - registered 2-to-4 decoder with enable and parameterised output polarity.
// Optional status outputs (idx_q, hit_cnt, onehot_err) are built when MY_DECODER_STATUS_EN is defined.
module my_decoder #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit RESET_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       I0,
  input  logic       I1,
  output logic       m0,
  output logic       m1,
  output logic       m2,
  output logic       m3
`ifdef MY_DECODER_STATUS_EN
  ,
  output logic [1:0] idx_q,
  output logic [7:0] hit_cnt,
  output logic [0:0] onehot_err
`endif
);

  localparam logic [3:0] POL_MASK  = {4{ACTIVE_LOW}};
  localparam logic [3:0] M_RST_VAL = RESET_IDLE ? POL_MASK : 4'b0000;

  logic [3:0] raw_d;
  logic [3:0] raw_q;
  logic [3:0] m_d;
  logic [3:0] m_q;

  // Each term is ANDed with E so unknown select bits cannot leak through while disabled.
  always_comb begin
    raw_d    = 4'b0000;
    raw_d[0] = E & ~I1 & ~I0;
    raw_d[1] = E & ~I1 &  I0;
    raw_d[2] = E &  I1 & ~I0;
    raw_d[3] = E &  I1 &  I0;
    m_d      = raw_d ^ POL_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 4'b0000;
      m_q   <= M_RST_VAL;
    end else begin
      raw_q <= raw_d;
      m_q   <= m_d;
    end
  end

  assign m0 = m_q[0];
  assign m1 = m_q[1];
  assign m2 = m_q[2];
  assign m3 = m_q[3];

`ifdef MY_DECODER_STATUS_EN
  logic [1:0] idx_d;
  logic [7:0] hit_cnt_d;
  logic [7:0] hit_cnt_q;
  logic       onehot_err_d;
  logic       onehot_err_q;

  always_comb begin
    idx_d        = idx_q;
    hit_cnt_d    = hit_cnt_q;
    onehot_err_d = onehot_err_q;
    if (E) begin
      idx_d = {I1, I0};
      if (hit_cnt_q != 8'hFF) begin
        hit_cnt_d = hit_cnt_q + 8'd1;
      end
    end
    // More than one bit set means clearing the lowest set bit leaves something behind.
    if ((raw_q & (raw_q - 4'd1)) != 4'b0000) begin
      onehot_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= 2'b00;
      hit_cnt_q    <= 8'd0;
      onehot_err_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      hit_cnt_q    <= hit_cnt_d;
      onehot_err_q <= onehot_err_d;
    end
  end

  assign hit_cnt       = hit_cnt_q;
  assign onehot_err[0] = onehot_err_q;
`endif

endmodule

// File: tb/tb_my_decoder.sv
// tb/tb_my_decoder.sv - self-checking bench for my_decoder, default and active-low instances.
// Status outputs are exercised when MY_DECODER_STATUS_EN is defined.
module tb_my_decoder;

  logic clk;
  logic rst;
  logic E;
  logic I0;
  logic I1;
  logic m0, m1, m2, m3;
  logic a0, a1, a2, a3;
`ifdef MY_DECODER_STATUS_EN
  logic [1:0] idx_q, idx_q_al;
  logic [7:0] hit_cnt, hit_cnt_al;
  logic [0:0] onehot_err, onehot_err_al;
`endif

  int total;
  int bad;

  wire [3:0] m_vec  = {m3, m2, m1, m0};
  wire [3:0] al_vec = {a3, a2, a1, a0};

  my_decoder u_dut (
    .clk(clk), .rst(rst), .E(E), .I0(I0), .I1(I1),
    .m0(m0), .m1(m1), .m2(m2), .m3(m3)
`ifdef MY_DECODER_STATUS_EN
    , .idx_q(idx_q), .hit_cnt(hit_cnt), .onehot_err(onehot_err)
`endif
  );

  my_decoder #(.ACTIVE_LOW(1'b1), .RESET_IDLE(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .E(E), .I0(I0), .I1(I1),
    .m0(a0), .m1(a1), .m2(a2), .m3(a3)
`ifdef MY_DECODER_STATUS_EN
    , .idx_q(idx_q_al), .hit_cnt(hit_cnt_al), .onehot_err(onehot_err_al)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: asserted line is 2**sel when enabled, nothing otherwise.
  function automatic logic [3:0] model_m(input logic e, input int sel);
    int v;
    v = e ? (1 << sel) : 0;
    return v[3:0];
  endfunction

  // At most one output asserted on the active-high instance, every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (!$onehot0(m_vec)) begin
        bad++;
        $display("FAIL onehot_invariant got=%b required=at most one bit set", m_vec);
      end
    end
  end

  task automatic drive_cycle(input logic e, input int sel);
    logic [1:0] s;
    s = sel[1:0];
    @(negedge clk);
    E  = e;
    I1 = s[1];
    I0 = s[0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; E = 1'b1; I1 = 1'b1; I0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (m_vec !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d got=%b required=0000", c, m_vec);
      end
      total++;
      if (al_vec !== 4'b1111) begin
        bad++;
        $display("FAIL reset_hold_al cycle=%0d got=%b required=1111", c, al_vec);
      end
    end
`ifdef MY_DECODER_STATUS_EN
    total++;
    if (hit_cnt !== 8'd0 || idx_q !== 2'b00 || onehot_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_status got=%0d/%b/%b required=0/00/0", hit_cnt, idx_q, onehot_err);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (m_vec !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release got=%b required=1000", m_vec);
    end
  endtask

  task automatic test_disable;
    for (int s = 0; s < 4; s++) begin
      drive_cycle(1'b0, s);
      total++;
      if (m_vec !== 4'b0000) begin
        bad++;
        $display("FAIL disable sel=%0d got=%b required=0000", s, m_vec);
      end
      total++;
      if (al_vec !== 4'b1111) begin
        bad++;
        $display("FAIL disable_al sel=%0d got=%b required=1111", s, al_vec);
      end
    end
  endtask

  task automatic test_enable;
    logic [3:0] exp;
    for (int s = 0; s < 4; s++) begin
      drive_cycle(1'b1, s);
      exp = model_m(1'b1, s);
      total++;
      if (m_vec !== exp) begin
        bad++;
        $display("FAIL enable sel=%0d got=%b required=%b", s, m_vec, exp);
      end
      total++;
      if (al_vec !== ~exp) begin
        bad++;
        $display("FAIL enable_al sel=%0d got=%b required=%b", s, al_vec, ~exp);
      end
    end
  endtask

  task automatic test_random;
    logic e;
    int s;
    logic [3:0] exp;
    for (int n = 0; n < 60; n++) begin
      e = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 3));
      drive_cycle(e, s);
      exp = model_m(e, s);
      total++;
      if (m_vec !== exp || al_vec !== ~exp) begin
        bad++;
        $display("FAIL random n=%0d e=%0d sel=%0d got=%b/%b required=%b/%b",
                 n, e, s, m_vec, al_vec, exp, ~exp);
      end
    end
  endtask

  task automatic test_latency_async_reset;
    drive_cycle(1'b1, 0);
    // Inputs wiggle mid-cycle; only the value at the edge should be captured.
    #2; E = 1'b1; I1 = 1'b1; I0 = 1'b0;
    #1;
    total++;
    if (m_vec !== 4'b0001) begin
      bad++;
      $display("FAIL latency_midcycle got=%b required=0001", m_vec);
    end
    @(negedge clk);
    I1 = 1'b0; I0 = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (m_vec !== 4'b0010) begin
      bad++;
      $display("FAIL latency_edge got=%b required=0010", m_vec);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (m_vec !== 4'b0000 || al_vec !== 4'b1111) begin
      bad++;
      $display("FAIL async_reset got=%b/%b required=0000/1111", m_vec, al_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    E = 1'b1; I1 = 1'b1; I0 = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (m_vec !== 4'b0100 || al_vec !== 4'b1011) begin
      bad++;
      $display("FAIL first_capture got=%b/%b required=0100/1011", m_vec, al_vec);
    end
  endtask

  task automatic test_unknown_select;
    @(negedge clk);
    E = 1'b0; I1 = 1'bz; I0 = 1'bx;
    @(posedge clk);
    #1;
    total++;
    if (m_vec !== 4'b0000 || al_vec !== 4'b1111) begin
      bad++;
      $display("FAIL unknown_select got=%b/%b required=0000/1111", m_vec, al_vec);
    end
  endtask

`ifdef MY_DECODER_STATUS_EN
  task automatic test_status;
    int s;
    for (int n = 0; n < 300; n++) begin
      s = (n == 299) ? 1 : int'($urandom_range(0, 3));
      drive_cycle(1'b1, s);
      total++;
      if (onehot_err !== 1'b0) begin
        bad++;
        $display("FAIL onehot_err n=%0d got=%b required=0", n, onehot_err);
      end
    end
    total++;
    if (hit_cnt !== 8'd255) begin
      bad++;
      $display("FAIL hit_cnt_saturate got=%0d required=255", hit_cnt);
    end
    total++;
    if (idx_q !== 2'b01) begin
      bad++;
      $display("FAIL idx_q got=%b required=01", idx_q);
    end
    drive_cycle(1'b0, 3);
    total++;
    if (idx_q !== 2'b01 || hit_cnt !== 8'd255) begin
      bad++;
      $display("FAIL status_hold_disabled got=%b/%0d required=01/255", idx_q, hit_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; E = 1'b0; I0 = 1'b0; I1 = 1'b0;
    test_reset();
    test_disable();
    test_enable();
    test_random();
    test_latency_async_reset();
    test_unknown_select();
`ifdef MY_DECODER_STATUS_EN
    test_status();
`endif
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_decoder.md
Name: my_decoder

Overview:
- Registered 2-to-4 line decoder with active-high enable.
- Decodes select inputs I1:I0 into a one-hot output m3..m0, which is captured in a flop stage on the rising clock edge.
- Used as a small control-path address or select decoder.
- Output polarity is a parameter, so the block can drive active-low chip-select style loads.

Parameters:
- ACTIVE_LOW, 0, 0 = asserted output is 1 and idle is 0; 1 = all four outputs are inverted (asserted 0, idle 1).
- RESET_IDLE, 1, 1 = reset loads the idle pattern; 0 = reset loads the all-zero raw pattern before polarity inversion. Both settings give the same result when ACTIVE_LOW=0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- E  input  1  decoder enable, active high.
- I0  input  1  select bit 0 (LSB).
- I1  input  1  select bit 1 (MSB).
- m0  output  1  asserted when E=1 and {I1,I0}=00.
- m1  output  1  asserted when E=1 and {I1,I0}=01.
- m2  output  1  asserted when E=1 and {I1,I0}=10.
- m3  output  1  asserted when E=1 and {I1,I0}=11.
- Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Select index is idx = 2*I1 + I0. I1 is the MSB.
- Raw decode:
  - raw[k] = E & (idx == k) for k = 0..3.
  - E=0 gives raw = 0000 regardless of I1/I0.
  - E=1 gives exactly one bit of raw set.
- Output: m[k] = raw_q[k] XOR ACTIVE_LOW, where raw_q is the registered copy of raw.
- Latency:
  - Outputs reflect inputs sampled at rising edge N, visible after edge N.
  - Exactly 1 cycle of latency; no combinational path from inputs to outputs.
- Reset:
  - rst=1 clears raw_q to 0000 immediately, without waiting for clk.
  - Resulting outputs: m3..m0 = 0000 if ACTIVE_LOW=0; 1111 if ACTIVE_LOW=1 and RESET_IDLE=1.
- Reset mid-operation: outputs go to the reset value asynchronously. The first capture occurs on the first rising edge after rst deasserts.
- Input changes between edges have no effect; only the value present at the edge is captured.
- X/Z on I1/I0 while E=0: outputs must still be idle, so the enable term gates the select bits.
- One-hot invariant: at most one raw_q bit set at any time. A bench assertion checks this every cycle.
- No handshake and no back-pressure; a new decode is accepted every cycle.

Optional Feature:
- Macro: MY_DECODER_STATUS_EN.
- When defined, adds the following:
  - Output idx_q [1:0]: registered select index. Updates only on cycles where E=1; resets to 0.
  - Output hit_cnt [7:0]: counts cycles where E=1; resets to 0; saturates at 255 with no wrap.
  - Output onehot_err [0:0]: registered flag, set when raw_q has more than one bit set. It is a sticky flag cleared only by rst. It must never set in a correct design.
- When not defined, these ports and their logic are absent. Core behaviour is identical with and without the macro.

Test Plan:
- Reset: hold rst=1 with E=1, I1I0=11 and toggle clk -> m3..m0 = 0000 throughout. Release rst, then one edge later -> m3..m0 = 1000.
- Disable sweep: E=0, I1I0 = 00, 01, 10, 11, each held 1 cycle -> m3..m0 = 0000 every cycle.
- Enable sweep: E=1, I1I0 = 00, 01, 10, 11 -> m3..m0 one cycle later = 0001, 0010, 0100, 1000.
- Latency and async reset: change inputs mid-cycle -> outputs change only at the next edge. Assert rst between edges -> outputs become 0000 before the next edge.
- ACTIVE_LOW=1 build:
  - E=1, I1I0=10 -> m3..m0 = 1011.
  - E=0 -> 1111.
  - Reset -> 1111.
- MY_DECODER_STATUS_EN build: run 300 cycles with E=1 -> hit_cnt = 255 (saturated). Last I1I0=01 -> idx_q = 01. onehot_err = 0 throughout.
